// File: rtl/data_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_pkg
// Description : Shared constants for the data-memory arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_arbiter_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [0:0] PORT_LSU = 1'b0;
    localparam logic [0:0] PORT_DBG = 1'b1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Combinational two-way round-robin grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import data_memory_arbiter_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req_valid;
        grant_idx   = PORT_LSU;
        // On a tie the port that did not win last time takes the grant.
        if (req_valid[PORT_LSU] && req_valid[PORT_DBG]) begin
            grant_idx = (last_grant == PORT_LSU) ? PORT_DBG : PORT_LSU;
        end else if (req_valid[PORT_DBG]) begin
            grant_idx = PORT_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Shares the data-memory port between the LSU and debug loader.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req_valid,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [NUM_PORTS-1:0]              req_wren,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_address,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_byteena,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [DATA_WIDTH/8-1:0]           mem_byteena,
    output logic [DATA_WIDTH-1:0]             mem_data,
    output logic                              mem_wren,
    input  logic [DATA_WIDTH-1:0]             mem_q
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W    = 3;

    logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
    logic [BE_WIDTH-1:0]   port_be   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign port_addr[p] = req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_be[p]   = req_byteena[p*BE_WIDTH +: BE_WIDTH];
        assign port_data[p] = req_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [0:0]            state;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [BE_WIDTH-1:0]   hold_be;
    logic                  hold_owner;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  grant_valid;
    logic                  grant_idx;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req_valid   (req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        req_ready   = '0;
        mem_address = '0;
        mem_byteena = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (state == ST_IDLE) begin
            if (grant_valid) begin
                req_ready[grant_idx] = 1'b1;
                mem_address          = port_addr[grant_idx];
                mem_byteena          = port_be[grant_idx];
                mem_data             = port_data[grant_idx];
                mem_wren             = req_wren[grant_idx];
            end
        end else begin
            // RAM and IO read paths differ in depth, so the address stays put.
            mem_address = hold_addr;
            mem_byteena = hold_be;
        end
        if (!reset) begin
            req_ready = '0;
            mem_wren  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            hold_addr  <= '0;
            hold_be    <= '0;
            hold_owner <= 1'b0;
            wait_cnt   <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_idx;
                        if (!req_wren[grant_idx]) begin
                            hold_addr  <= port_addr[grant_idx];
                            hold_be    <= port_be[grant_idx];
                            hold_owner <= grant_idx;
                            wait_cnt   <= CNT_W'(RD_LATENCY - 1);
                            state      <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_data              <= mem_q;
                        rsp_valid[hold_owner] <= 1'b1;
                        state                 <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
